mod_counter_nbit: RTL and testbench

//   Parametrised successor to the fixed 4-bit up-counter: WIDTH-bit up/down modulo-N counter

---
 rtl/mod_counter_nbit_pkg.sv | 13 +
 rtl/mod_counter_nbit_if.sv | 23 ++
 rtl/mod_counter_nbit_prescale_tick.sv | 42 ++++
 rtl/mod_counter_nbit.sv | 108 ++++++++++
 tb/tb_mod_counter_nbit.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mod_counter_nbit_pkg.sv
// Shared definitions for the counter family: direction encoding and load clamping.
package counter_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Out-of-range loads land on the top of the count range instead of aliasing.
    function automatic logic [31:0] clamp_load(input logic [31:0] value,
                                               input logic [31:0] modulus);
        return (value >= modulus) ? (modulus - 32'd1) : value;
    endfunction

endpackage

// File: rtl/mod_counter_nbit_if.sv
// Control/status bundle of mod_counter_nbit; master drives controls, slave returns count/tc/sat.
// All signals are level-based and sampled on the rising clock edge; there is no handshake.
interface mod_counter_nbit_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             sat;

    modport master (
        output en, up_dn, load, load_val,
        input  count, tc, sat
    );

    modport slave (
        input  en, up_dn, load, load_val,
        output count, tc, sat
    );
endinterface

// File: rtl/mod_counter_nbit_prescale_tick.sv
// Prescaler: emits a step pulse on every PRESCALE-th enabled cycle; clr/rst restart the phase.
module prescale_tick #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic step_o
);

    if (PRESCALE == 1) begin : g_bypass
        wire unused_clk = clk;
        assign step_o = en_i & ~clr_i & ~rst;
    end else begin : g_div
        localparam int PW = $clog2(PRESCALE);
        localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

        logic [PW-1:0] phase_q;
        logic [PW-1:0] phase_d;

        always_comb begin
            phase_d = phase_q;
            if (clr_i) begin
                phase_d = '0;
            end else if (en_i) begin
                phase_d = (phase_q == LAST) ? '0 : phase_q + 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                phase_q <= '0;
            end else begin
                phase_q <= phase_d;
            end
        end

        assign step_o = en_i & ~clr_i & ~rst & (phase_q == LAST);
    end

endmodule

// File: rtl/mod_counter_nbit.sv
// WIDTH-bit up/down modulo-MODULUS counter with load, enable, prescaler and terminal-count pulse.
// Define COUNTER_SATURATE_EN to saturate at the range limits (sat flag) instead of wrapping.
module mod_counter_nbit
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int PRESCALE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    mod_counter_nbit_if.slave     bus
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             step;
    logic [WIDTH-1:0] load_clamped;

    assign load_clamped = WIDTH'(clamp_load(32'(bus.load_val), 32'(MODULUS)));

    prescale_tick #(
        .PRESCALE (PRESCALE)
    ) u_prescale (
        .clk    (clk),
        .rst    (rst),
        .en_i   (bus.en),
        .clr_i  (bus.load),
        .step_o (step)
    );

`ifdef COUNTER_SATURATE_EN
    logic sat_q, sat_d;
    logic at_limit;

    // Limit depends on the direction currently requested, so a reversal drops sat.
    assign at_limit = (bus.up_dn == DIR_UP) ? (count_q == MAX) : (count_q == '0);

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        sat_d   = sat_q & at_limit;
        if (bus.load) begin
            count_d = load_clamped;
            sat_d   = 1'b0;
        end else if (step) begin
            if (at_limit) begin
                sat_d = 1'b1;
            end else begin
                count_d = (bus.up_dn == DIR_UP) ? count_q + 1'b1 : count_q - 1'b1;
                sat_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign bus.sat = sat_q;
`else
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (bus.load) begin
            count_d = load_clamped;
        end else if (step) begin
            if (bus.up_dn == DIR_UP) begin
                if (count_q == MAX) begin
                    count_d = '0;
                    tc_d    = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end else begin
                if (count_q == '0) begin
                    count_d = MAX;
                    tc_d    = 1'b1;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
        end
    end

    assign bus.sat = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;

endmodule

// File: tb/tb_mod_counter_nbit.sv
// Directed bench for mod_counter_nbit: three configurations share one stimulus set.
// Wrap scenarios run in the default build; COUNTER_SATURATE_EN selects the saturation scenario.
module tb_mod_counter_nbit;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_val;

    int checks;
    int errors;

    mod_counter_nbit_if #(.WIDTH(4)) if_def ();
    mod_counter_nbit_if #(.WIDTH(4)) if_m10 ();
    mod_counter_nbit_if #(.WIDTH(4)) if_p3 ();

    assign if_def.en = en;  assign if_def.up_dn = up_dn;
    assign if_def.load = load;  assign if_def.load_val = load_val;
    assign if_m10.en = en;  assign if_m10.up_dn = up_dn;
    assign if_m10.load = load;  assign if_m10.load_val = load_val;
    assign if_p3.en = en;  assign if_p3.up_dn = up_dn;
    assign if_p3.load = load;  assign if_p3.load_val = load_val;

    mod_counter_nbit #(.WIDTH(4), .MODULUS(16), .PRESCALE(1)) u_def (
        .clk (clk), .rst (rst), .bus (if_def)
    );
    mod_counter_nbit #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_m10 (
        .clk (clk), .rst (rst), .bus (if_m10)
    );
    mod_counter_nbit #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) u_p3 (
        .clk (clk), .rst (rst), .bus (if_p3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 4'd0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (if_def.count !== 4'd0 || if_def.tc !== 1'b0 || if_def.sat !== 1'b0) begin
            errors++;
            $display("FAIL reset_def: count=%0d tc=%b sat=%b required 0/0/0",
                     if_def.count, if_def.tc, if_def.sat);
        end
        checks++;
        if (if_m10.count !== 4'd0 || if_p3.count !== 4'd0 || if_p3.tc !== 1'b0) begin
            errors++;
            $display("FAIL reset_others: m10=%0d p3=%0d p3_tc=%b required 0/0/0",
                     if_m10.count, if_p3.count, if_p3.tc);
        end
    endtask

    task automatic test_up_wrap();
        logic [3:0] exp_c;
        do_reset();
        en = 1'b1; up_dn = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            tick();
            exp_c = 4'(i % 16);
            checks++;
            if (if_def.count !== exp_c || if_def.tc !== (i == 16)) begin
                errors++;
                $display("FAIL up_wrap[%0d]: count=%0d tc=%b required %0d/%b",
                         i, if_def.count, if_def.tc, exp_c, (i == 16));
            end
        end
    endtask

    task automatic test_down_mod10();
        logic [3:0] exp_c[3];
        exp_c[0] = 4'd9; exp_c[1] = 4'd8; exp_c[2] = 4'd7;
        do_reset();
        en = 1'b1; up_dn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (if_m10.count !== exp_c[i] || if_m10.tc !== (i == 0)) begin
                errors++;
                $display("FAIL down_mod10[%0d]: count=%0d tc=%b required %0d/%b",
                         i, if_m10.count, if_m10.tc, exp_c[i], (i == 0));
            end
        end
    endtask

    task automatic test_prescale();
        logic [3:0] exp_c[9];
        logic       en_v[9];
        exp_c[0] = 4'd0; exp_c[1] = 4'd0; exp_c[2] = 4'd1; exp_c[3] = 4'd1;
        exp_c[4] = 4'd1; exp_c[5] = 4'd1;
        exp_c[6] = 4'd1; exp_c[7] = 4'd2; exp_c[8] = 4'd2;
        for (int i = 0; i < 9; i++) en_v[i] = !(i == 4 || i == 5);
        do_reset();
        up_dn = 1'b1;
        for (int i = 0; i < 9; i++) begin
            en = en_v[i];
            tick();
            checks++;
            if (if_p3.count !== exp_c[i] || if_p3.tc !== 1'b0) begin
                errors++;
                $display("FAIL prescale[%0d]: count=%0d tc=%b required %0d/0",
                         i, if_p3.count, if_p3.tc, exp_c[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_load();
        do_reset();
        load = 1'b1; load_val = 4'd7;
        tick();
        checks++;
        if (if_m10.count !== 4'd7 || if_m10.tc !== 1'b0) begin
            errors++;
            $display("FAIL load_7: count=%0d tc=%b required 7/0", if_m10.count, if_m10.tc);
        end
        load_val = 4'd12;
        tick();
        checks++;
        if (if_m10.count !== 4'd9) begin
            errors++;
            $display("FAIL load_clamp: count=%0d required 9", if_m10.count);
        end
        en = 1'b1; up_dn = 1'b1; load_val = 4'd9;
        tick();
        checks++;
        if (if_m10.count !== 4'd9 || if_m10.tc !== 1'b0) begin
            errors++;
            $display("FAIL load_wins: count=%0d tc=%b required 9/0", if_m10.count, if_m10.tc);
        end
`ifndef COUNTER_SATURATE_EN
        load = 1'b0;
        tick();
        checks++;
        if (if_m10.count !== 4'd0 || if_m10.tc !== 1'b1) begin
            errors++;
            $display("FAIL load_then_wrap: count=%0d tc=%b required 0/1",
                     if_m10.count, if_m10.tc);
        end
`endif
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        checks++;
        if (if_p3.count !== 4'd5) begin
            errors++;
            $display("FAIL mid_reset_pre: count=%0d required 5", if_p3.count);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (if_p3.count !== 4'd0 || if_p3.tc !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: count=%0d tc=%b required 0/0", if_p3.count, if_p3.tc);
        end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (if_p3.count !== ((i == 3) ? 4'd1 : 4'd0)) begin
                errors++;
                $display("FAIL mid_reset_step[%0d]: count=%0d required %0d",
                         i, if_p3.count, (i == 3) ? 1 : 0);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        en = 1'b1; up_dn = 1'b0;
        tick();
        checks++;
        if (if_def.count !== 4'd15 || if_def.tc !== 1'b1) begin
            errors++;
            $display("FAIL b2b_down: count=%0d tc=%b required 15/1", if_def.count, if_def.tc);
        end
        up_dn = 1'b1;
        tick();
        checks++;
        if (if_def.count !== 4'd0 || if_def.tc !== 1'b1 || if_def.sat !== 1'b0) begin
            errors++;
            $display("FAIL b2b_up: count=%0d tc=%b sat=%b required 0/1/0",
                     if_def.count, if_def.tc, if_def.sat);
        end
        tick();
        checks++;
        if (if_def.count !== 4'd1 || if_def.tc !== 1'b0) begin
            errors++;
            $display("FAIL b2b_after: count=%0d tc=%b required 1/0", if_def.count, if_def.tc);
        end
        en = 1'b0;
    endtask

`ifdef COUNTER_SATURATE_EN
    task automatic test_saturate();
        do_reset();
        load = 1'b1; load_val = 4'd8;
        tick();
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (if_m10.count !== 4'd9 || if_m10.tc !== 1'b0 || if_m10.sat !== (i > 0)) begin
                errors++;
                $display("FAIL saturate[%0d]: count=%0d tc=%b sat=%b required 9/0/%b",
                         i, if_m10.count, if_m10.tc, if_m10.sat, (i > 0));
            end
        end
        up_dn = 1'b0;
        tick();
        checks++;
        if (if_m10.count !== 4'd8 || if_m10.sat !== 1'b0) begin
            errors++;
            $display("FAIL sat_reverse: count=%0d sat=%b required 8/0", if_m10.count, if_m10.sat);
        end
        en = 1'b0;
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_prescale();
        test_load();
        test_mid_reset();
`ifdef COUNTER_SATURATE_EN
        test_saturate();
`else
        test_up_wrap();
        test_down_mod10();
        test_back_to_back();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
